i2s_clock_ctrl: RTL
===================

# i2s_clock_ctrl

Master-mode I2S clock and capture sequencer that drives `i2s_receive`. It derives `sck` and `ws` from the AXI-Stream clock and starts and stops capture on stereo-frame boundaries only. It also provides per-edge strobes and optional capture statistics. It sits between the system control registers and `i2s_receive`/the microphone, replacing the free-running clocks used in bring-up benches.

## Interface
- `SCK_DIV`, 8: `M_AXIS_ACLK` cycles per `sck` period; even, ≥2.
- `BITS_PER_SLOT`, 32: `sck` periods per `ws` half (one channel slot); ≥2.
- `M_AXIS_ACLK`  in  1  sole clock; all logic rising-edge.
- `M_AXIS_ARESET`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; 1 requests capture, 0 requests stop at the next frame boundary.
- `stat_clr`  in  1  one-cycle pulse; clears statistics.
- `mon_tvalid`  in  1  monitor tap of `i2s_receive` `M_AXIS_TVALID`.
- `mon_tready`  in  1  monitor tap of `M_AXIS_TREADY`.
- `sck`  out  1  I2S bit clock.
- `ws`  out  1  I2S word select; 0 = left slot, 1 = right slot.
- `sck_rise`  out  1  one-cycle strobe, coincident with `sck` 0→1.
- `sck_fall`  out  1  one-cycle strobe, coincident with `sck` 1→0.
- `frame_start`  out  1  one-cycle strobe on the first cycle of each stereo frame.
- `busy`  out  1  1 while state ≠ IDLE.
- `frame_count`  out  32  completed stereo frames; wraps.
- `overrun_count`  out  16  frames started while the downstream sample was unaccepted; saturating.

## Operation
- States: IDLE, RUN, DRAIN.
- Counters:
  - `div_cnt` runs 0..SCK_DIV-1.
  - `bit_cnt` runs 0..2·BITS_PER_SLOT-1 and advances when `div_cnt` wraps.
- Waveforms:
  - `sck` = (`div_cnt` ≥ SCK_DIV/2).
  - `ws` = (`bit_cnt` ≥ BITS_PER_SLOT).
  - `ws` therefore changes only on `sck` falling edges (Philips timing).
- All outputs are registered. Reset value of every output is 0, and state is IDLE.
- IDLE:
  - Counters are held at 0; `sck`=`ws`=0 and all strobes are 0.
  - `enable`=1 → RUN.
- RUN:
  - Counters free-run.
  - `frame_start`=1 when `div_cnt`=0 and `bit_cnt`=0.
  - `enable`=0 → DRAIN.
- DRAIN:
  - Counters continue.
  - On the last cycle of the frame (`bit_cnt`=max, `div_cnt`=max): → IDLE and counters return to 0.
  - `enable`=1 during DRAIN → RUN with no phase disturbance.
- Simultaneous events:
  - Frame end in DRAIN with `enable`=1 in the same cycle → RUN; the frame continues seamlessly.
  - `stat_clr` together with an increment → clear wins.
- Reset mid-frame: next cycle is IDLE with `sck`=`ws`=0. A truncated frame is acceptable; `i2s_receive` resynchronises on the next `ws` edge.
- Statistics (see Configuration):
  - `frame_count` += 1 on each frame's last cycle.
  - `overrun_count` += 1 on each `frame_start` cycle where `mon_tvalid`=1 and `mon_tready`=0; saturates at 16'hFFFF.

## Timing
- `enable` sampled high at edge N → first RUN cycle N+1, with `frame_start`=1, `sck`=0, `ws`=0.
- Defaults (SCK_DIV=8, BITS_PER_SLOT=32):
  - `sck` rises 4 cycles into the frame and falls every 8 cycles.
  - `ws` rises at frame cycle 256.
  - Frame length is 512 cycles.
- `sck_rise` and `sck_fall` are asserted in the same cycle the `sck` output changes.
- Deassert latency: IDLE is reached 1 cycle after the last frame cycle; worst case 2·BITS_PER_SLOT·SCK_DIV cycles after `enable` falls.
- Statistics update one cycle after the triggering condition.

## Configuration
- Macro: `I2S_CLOCK_CTRL_STATS_EN`.
- Defined: the `frame_count` and `overrun_count` logic is built as described.
- Undefined:
  - Ports remain; `frame_count` and `overrun_count` are tied to 0.
  - `stat_clr`, `mon_tvalid` and `mon_tready` are ignored.
  - Sequencing behaviour is identical in both builds.

## Structure
- Package `i2s_pkg`:
  - state enum (IDLE/RUN/DRAIN);
  - default SCK_DIV and BITS_PER_SLOT constants;
  - statistic width constants (32, 16).
- Sub-module `i2s_clk_div`:
  - owns `div_cnt`, `sck`, `sck_rise`, `sck_fall`;
  - exposes a wrap strobe to the top level, which owns `bit_cnt`, `ws`, the FSM and statistics.

## Test plan
- Reset, then hold `enable`=1 → first `frame_start` at cycle 1; `sck` period 8; `ws` high for cycles 256–511; `busy`=1.
- Drop `enable` at frame cycle 100 → activity continues to cycle 511; IDLE at 512; `sck`=`ws`=0; `frame_count`=1.
- Drop `enable` at frame cycle 100, raise it at cycle 300 → no gap; `frame_start` again at cycle 512; `busy` stays 1.
- Hold `mon_tvalid`=1 and `mon_tready`=0 for 3 frames → `overrun_count`=3. Pulse `stat_clr` on a frame-end cycle → both counters read 0.
- Force `overrun_count` to 16'hFFFF and add another overrun → it stays 16'hFFFF. Build without `I2S_CLOCK_CTRL_STATS_EN` → both counters read 0 throughout.
- Assert `M_AXIS_ARESET` at frame cycle 300 → next cycle all outputs are 0; with `enable`=1 after release, a fresh `frame_start` follows.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S master clock sequencer.
// Holds the FSM state enum, default divider/slot sizes and statistic widths.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned SCK_DIV_DEF       = 8;
    localparam int unsigned BITS_PER_SLOT_DEF = 32;

    localparam int unsigned FRAME_CNT_W = 32;
    localparam int unsigned OVR_CNT_W   = 16;

endpackage

// File: rtl/i2s_clk_div.sv
// Bit-clock divider: owns div_cnt and produces sck plus edge strobes.
// Ports: clk, rst (sync, high), run (count enable), strobe_en (allow
// edge strobes next cycle) -> sck, sck_rise, sck_fall, wrap (last div cycle).
module i2s_clk_div
    import i2s_pkg::*;
#(
    parameter int unsigned SCK_DIV = SCK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic strobe_en,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall,
    output logic wrap
);

    localparam int unsigned DW = $clog2(SCK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCK_DIV - 1);
    localparam logic [DW-1:0] HALF    = DW'(SCK_DIV / 2);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic          sck_nxt;

    assign wrap = run && (div_cnt == DIV_MAX);

    // Wrapping on the last cycle also parks the counter at 0 when the
    // sequencer drops back to IDLE, so no separate clear is needed.
    always_comb begin
        div_nxt = '0;
        if (run && !wrap) begin
            div_nxt = div_cnt + DW'(1);
        end
        sck_nxt = (div_nxt >= HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            sck      <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            sck      <= sck_nxt;
            sck_rise <= strobe_en && !sck && sck_nxt;
            sck_fall <= strobe_en && sck && !sck_nxt;
        end
    end

endmodule

// File: rtl/i2s_clock_ctrl.sv
// Master-mode I2S sck/ws generator that starts/stops on frame boundaries.
// Ports: M_AXIS_ACLK, M_AXIS_ARESET (sync, high), enable, stat_clr,
// mon_tvalid, mon_tready -> sck, ws, sck_rise, sck_fall, frame_start, busy,
// frame_count, overrun_count. Statistics built only with
// I2S_CLOCK_CTRL_STATS_EN defined; otherwise the counters read 0.
module i2s_clock_ctrl
    import i2s_pkg::*;
#(
    parameter int unsigned SCK_DIV       = SCK_DIV_DEF,
    parameter int unsigned BITS_PER_SLOT = BITS_PER_SLOT_DEF
) (
    input  logic                   M_AXIS_ACLK,
    input  logic                   M_AXIS_ARESET,
    input  logic                   enable,
    input  logic                   stat_clr,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,
    output logic                   sck,
    output logic                   ws,
    output logic                   sck_rise,
    output logic                   sck_fall,
    output logic                   frame_start,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [OVR_CNT_W-1:0]   overrun_count
);

    localparam int unsigned FRAME_BITS = 2 * BITS_PER_SLOT;
    localparam int unsigned BW = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] BIT_MAX = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] SLOT    = BW'(BITS_PER_SLOT);

    state_e        state;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;
    logic          run;
    logic          wrap;
    logic          frame_end;
    logic          stop;

    assign run       = (state != IDLE);
    assign frame_end = wrap && (bit_cnt == BIT_MAX);
    // Only a draining frame that ends with enable low returns to IDLE.
    assign stop      = (state == DRAIN) && !enable && frame_end;

    i2s_clk_div #(
        .SCK_DIV   (SCK_DIV)
    ) u_div (
        .clk       (M_AXIS_ACLK),
        .rst       (M_AXIS_ARESET),
        .run       (run),
        .strobe_en (!stop),
        .sck       (sck),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .wrap      (wrap)
    );

    always_comb begin
        bit_nxt = '0;
        if (wrap) begin
            bit_nxt = (bit_cnt == BIT_MAX) ? '0 : bit_cnt + BW'(1);
        end else if (run) begin
            bit_nxt = bit_cnt;
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            ws          <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= RUN;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    frame_start <= frame_end;
                    if (!enable) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        frame_start <= frame_end;
                        if (enable) begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            bit_cnt <= bit_nxt;
            ws      <= (bit_nxt >= SLOT);
        end
    end

`ifdef I2S_CLOCK_CTRL_STATS_EN
    logic [FRAME_CNT_W-1:0] stat_frames;
    logic [OVR_CNT_W-1:0]   stat_ovr;

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET || stat_clr) begin
            stat_frames <= '0;
            stat_ovr    <= '0;
        end else begin
            if (frame_end) begin
                stat_frames <= stat_frames + FRAME_CNT_W'(1);
            end
            if (frame_start && mon_tvalid && !mon_tready &&
                (stat_ovr != '1)) begin
                stat_ovr <= stat_ovr + OVR_CNT_W'(1);
            end
        end
    end

    assign frame_count   = stat_frames;
    assign overrun_count = stat_ovr;
`else
    logic unused_stat;
    assign unused_stat   = ^{stat_clr, mon_tvalid, mon_tready};
    assign frame_count   = '0;
    assign overrun_count = '0;
`endif

endmodule
